// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: input conditioning, run/pause/adjust FSM,
// count-enable pulse generation and blink control for the display.
module stopwatch_ctrl #(
   parameter int TICK_DIV  = 100_000_000,
   parameter int ADJ_DIV   = 50_000_000,
   parameter int BLINK_DIV = 25_000_000,
   parameter int DB_CYCLES = 1_000_000
) (
   input  logic       incClk,
   input  logic       rst,
   input  logic       btn_pause,
   input  logic       btn_clr,
   input  logic       sw_adj,
   input  logic       sw_sel,
   output logic [1:0] state,
   output logic       inc_en,
   output logic       adj_min_en,
   output logic       adj_sec_en,
   output logic       clr,
   output logic       blank_min,
   output logic       blank_sec
);

   localparam logic [1:0] RUN    = 2'b00;
   localparam logic [1:0] PAUSED = 2'b01;
   localparam logic [1:0] ADJUST = 2'b10;

   localparam int TW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
   localparam int AW = (ADJ_DIV   > 1) ? $clog2(ADJ_DIV)   : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

   localparam logic [TW-1:0] TMAX = TW'(TICK_DIV - 1);
   localparam logic [AW-1:0] AMAX = AW'(ADJ_DIV - 1);
   localparam logic [BW-1:0] BMAX = BW'(BLINK_DIV - 1);
   localparam logic [DW-1:0] DMAX = DW'(DB_CYCLES - 1);

   // bit 0 pause, 1 clr, 2 adj, 3 sel
   logic [3:0]    s1, s2;
   logic [1:0]    db, db_d, press;
   logic [DW-1:0] dcnt [2];

   logic          pause_p, clr_p, adj, sel, sel_chg;
   logic [1:0]    saved, state_nxt, saved_nxt;
   logic [TW-1:0] tcnt, tcnt_nxt;
   logic [AW-1:0] acnt, acnt_nxt;
   logic [BW-1:0] bcnt, bcnt_nxt;
   logic          phase, phase_nxt;
   logic          inc_nxt, amin_nxt, asec_nxt;
   logic          bmin_nxt, bsec_nxt;

   always_ff @(posedge incClk or posedge rst) begin
      if (rst) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= {sw_sel, sw_adj, btn_clr, btn_pause};
         s2 <= s1;
      end
   end

   // level flips only after DB_CYCLES consecutive disagreeing samples
   always_ff @(posedge incClk or posedge rst) begin
      if (rst) begin
         db      <= '0;
         db_d    <= '0;
         dcnt[0] <= '0;
         dcnt[1] <= '0;
      end else begin
         db_d <= db;
         for (int i = 0; i < 2; i++) begin
            if (s2[i] != db[i]) begin
               if (dcnt[i] == DMAX) begin
                  db[i]   <= s2[i];
                  dcnt[i] <= '0;
               end else begin
                  dcnt[i] <= dcnt[i] + DW'(1);
               end
            end else begin
               dcnt[i] <= '0;
            end
         end
      end
   end

   assign press   = db & ~db_d;
   assign pause_p = press[0];
   assign clr_p   = press[1];
   assign adj     = s2[2];
   assign sel     = s2[3];
   assign sel_chg = s1[3] ^ s2[3];

   always_comb begin
      state_nxt = state;
      saved_nxt = saved;
      case (state)
         RUN: begin
            if (adj) begin
               state_nxt = ADJUST;
               saved_nxt = RUN;
            end else if (pause_p) begin
               state_nxt = PAUSED;
            end
         end
         PAUSED: begin
            if (adj) begin
               state_nxt = ADJUST;
               saved_nxt = PAUSED;
            end else if (pause_p) begin
               state_nxt = RUN;
            end
         end
         ADJUST: begin
            if (!adj) state_nxt = saved;
         end
         default: state_nxt = RUN;
      endcase
   end

   always_comb begin
      tcnt_nxt = tcnt;
      inc_nxt  = 1'b0;
      if (clr_p || (state == ADJUST && !adj)) begin
         tcnt_nxt = '0;
      end else if (state == RUN) begin
         if (tcnt == TMAX) begin
            tcnt_nxt = '0;
            inc_nxt  = 1'b1;
         end else begin
            tcnt_nxt = tcnt + TW'(1);
         end
      end

      acnt_nxt = '0;
      amin_nxt = 1'b0;
      asec_nxt = 1'b0;
      if (state == ADJUST && !sel_chg) begin
         if (acnt == AMAX) begin
            amin_nxt = !clr_p && !sel;
            asec_nxt = !clr_p && sel;
         end else begin
            acnt_nxt = acnt + AW'(1);
         end
      end

      bcnt_nxt  = '0;
      phase_nxt = 1'b0;
      if (state == ADJUST) begin
         if (bcnt == BMAX) begin
            phase_nxt = ~phase;
         end else begin
            bcnt_nxt  = bcnt + BW'(1);
            phase_nxt = phase;
         end
      end

      // blank tracks the state/sel values that become visible this edge
      bmin_nxt = (state_nxt == ADJUST) && !s1[3] && phase_nxt;
      bsec_nxt = (state_nxt == ADJUST) &&  s1[3] && phase_nxt;
   end

   always_ff @(posedge incClk or posedge rst) begin
      if (rst) begin
         state      <= RUN;
         saved      <= RUN;
         tcnt       <= '0;
         acnt       <= '0;
         bcnt       <= '0;
         phase      <= 1'b0;
         inc_en     <= 1'b0;
         adj_min_en <= 1'b0;
         adj_sec_en <= 1'b0;
         clr        <= 1'b0;
         blank_min  <= 1'b0;
         blank_sec  <= 1'b0;
      end else begin
         state      <= state_nxt;
         saved      <= saved_nxt;
         tcnt       <= tcnt_nxt;
         acnt       <= acnt_nxt;
         bcnt       <= bcnt_nxt;
         phase      <= phase_nxt;
         inc_en     <= inc_nxt;
         adj_min_en <= amin_nxt;
         adj_sec_en <= asec_nxt;
         clr        <= clr_p;
         blank_min  <= bmin_nxt;
         blank_sec  <= bsec_nxt;
      end
   end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomised bench for stopwatch_ctrl against a cycle-count
// reference model of the control rules.
module tb_stopwatch_ctrl;

   localparam int TICK  = 10;
   localparam int ADJ   = 4;
   localparam int BLINK = 3;
   localparam int DB    = 5;

   logic       incClk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_pause = 1'b0;
   logic       btn_clr = 1'b0;
   logic       sw_adj = 1'b0;
   logic       sw_sel = 1'b0;
   logic [1:0] state;
   logic       inc_en, adj_min_en, adj_sec_en, clr;
   logic       blank_min, blank_sec;

   stopwatch_ctrl #(
      .TICK_DIV(TICK), .ADJ_DIV(ADJ),
      .BLINK_DIV(BLINK), .DB_CYCLES(DB)
   ) dut (
      .incClk(incClk), .rst(rst),
      .btn_pause(btn_pause), .btn_clr(btn_clr),
      .sw_adj(sw_adj), .sw_sel(sw_sel),
      .state(state), .inc_en(inc_en),
      .adj_min_en(adj_min_en), .adj_sec_en(adj_sec_en),
      .clr(clr), .blank_min(blank_min), .blank_sec(blank_sec)
   );

   always #5 incClk = ~incClk;

   int n_chk = 0;
   int n_fail = 0;
   int n_inc = 0;

   // model: 0 RUN, 1 PAUSED, 2 ADJUST
   bit [3:0] m_s1, m_s2;
   bit [1:0] m_db, m_pend;
   int m_diff [2];
   int m_mode, m_saved, m_run, m_age, m_atime;
   bit [1:0] e_state;
   bit e_inc, e_amin, e_asec, e_clr, e_bmin, e_bsec;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h want %0h", tag, $time, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_db = '0; m_pend = '0;
      m_diff[0] = 0; m_diff[1] = 0;
      m_mode = 0; m_saved = 0; m_run = 0; m_age = 0; m_atime = 0;
      e_state = 2'b00;
      {e_inc, e_amin, e_asec, e_clr, e_bmin, e_bsec} = '0;
   endtask

   task automatic model_step();
      bit pp, cp, a, sl, nsl, exit_adj, ph;
      int nmode;
      pp  = m_pend[0];
      cp  = m_pend[1];
      a   = m_s2[2];
      sl  = m_s2[3];
      nsl = m_s1[3];
      nmode = m_mode;
      exit_adj = (m_mode == 2) && !a;
      if (m_mode != 2 && a) begin
         m_saved = m_mode;
         nmode = 2;
      end else if (exit_adj) begin
         nmode = m_saved;
      end else if (m_mode != 2 && pp) begin
         nmode = 1 - m_mode;
      end
      e_inc = 0; e_amin = 0; e_asec = 0;
      if (cp || exit_adj) m_run = 0;
      else if (m_mode == 0) begin
         m_run = (m_run + 1) % TICK;
         e_inc = (m_run == 0);
      end
      if (m_mode == 2 && sl == nsl) begin
         m_age++;
         if (m_age % ADJ == 0 && !cp) begin
            e_amin = !sl;
            e_asec = sl;
         end
      end else m_age = 0;
      if (m_mode == 2) m_atime++;
      else m_atime = 0;
      ph = ((m_atime / BLINK) % 2) == 1;
      e_bmin = (nmode == 2) && !nsl && ph;
      e_bsec = (nmode == 2) && nsl && ph;
      e_clr = cp;
      m_mode = nmode;
      e_state = 2'(nmode);
      for (int i = 0; i < 2; i++) begin
         m_pend[i] = 0;
         if (m_s2[i] != m_db[i]) begin
            m_diff[i]++;
            if (m_diff[i] == DB) begin
               m_db[i] = m_s2[i];
               m_diff[i] = 0;
               m_pend[i] = m_db[i];
            end
         end else m_diff[i] = 0;
      end
      m_s2 = m_s1;
      m_s1 = {sw_sel, sw_adj, btn_clr, btn_pause};
   endtask

   task automatic compare();
      chk("outs",
          {state, inc_en, adj_min_en, adj_sec_en, clr, blank_min, blank_sec},
          {e_state, e_inc, e_amin, e_asec, e_clr, e_bmin, e_bsec});
      chk("excl",
          32'($countones({inc_en, adj_min_en, adj_sec_en, clr}) <= 1), 1);
      if (inc_en) n_inc++;
   endtask

   task automatic tick(int n);
      repeat (n) begin
         @(posedge incClk);
         if (rst) model_reset();
         else model_step();
         #1;
         compare();
      end
   endtask

   task automatic hold_btn(bit which, int len);
      if (which) btn_clr = 1'b1;
      else btn_pause = 1'b1;
      tick(len);
      btn_clr = 1'b0;
      btn_pause = 1'b0;
   endtask

   initial begin
      model_reset();
      #2;
      compare();
      tick(2);
      @(negedge incClk);
      rst = 1'b0;
      n_inc = 0;
      tick(35);
      chk("inc_cnt35", n_inc, 3);

      hold_btn(0, 10);
      tick(10);
      chk("paused", state, 2'b01);
      hold_btn(0, 2);
      tick(10);
      chk("glitch_rej", state, 2'b01);

      sw_adj = 1'b1;
      tick(20);
      chk("adjust", state, 2'b10);
      sw_sel = 1'b1;
      tick(12);
      sw_adj = 1'b0;
      tick(5);
      chk("back_paused", state, 2'b01);
      hold_btn(0, 8);
      tick(10);
      chk("resumed", state, 2'b00);
      hold_btn(1, 8);
      tick(12);
      chk("clr_keeps_run", state, 2'b00);

      for (int k = 0; k < 150; k++) begin
         case ($urandom_range(0, 5))
            0: begin
               hold_btn(0, $urandom_range(1, 12));
               tick($urandom_range(0, 8));
            end
            1: begin
               hold_btn(1, $urandom_range(1, 12));
               tick($urandom_range(0, 8));
            end
            2: begin
               sw_adj = ~sw_adj;
               tick($urandom_range(2, 20));
            end
            3: begin
               sw_sel = ~sw_sel;
               tick($urandom_range(1, 15));
            end
            4: tick($urandom_range(1, 25));
            default: begin
               for (int j = 0; j < 8; j++) begin
                  btn_pause = 1'($urandom_range(0, 1));
                  btn_clr = 1'($urandom_range(0, 1));
                  tick(1);
               end
               btn_pause = 1'b0;
               btn_clr = 1'b0;
            end
         endcase
      end

      sw_adj = 1'b1;
      sw_sel = 1'b0;
      tick(8);
      #2;
      rst = 1'b1;
      sw_adj = 1'b0;
      #1;
      model_reset();
      chk("rst_async",
          {state, inc_en, adj_min_en, adj_sec_en, clr, blank_min, blank_sec},
          0);
      tick(3);
      rst = 1'b0;
      n_inc = 0;
      tick(25);
      chk("inc_after_rst", n_inc, 2);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
